// File: rtl/branch_resolver.sv
// branch_resolver: resolution side of the branch predictor interface.
// Queues fetch-time predictions in order, compares each against the execute
// outcome, trains the predictor and raises a one-cycle flush on a mispredict.
// Optional feature macro: BRANCH_RESOLVER_STATS_EN adds resolved/mispredict
// event counters as extra output ports.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            pred_ready,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            branch_resolved,
  output logic [XLEN-1:0] branch_pc,
  output logic            branch_outcome,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
`ifdef BRANCH_RESOLVER_STATS_EN
  output logic [31:0]     resolved_count,
  output logic [31:0]     mispredict_count,
`endif
  output logic            order_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Prediction storage; payload only, so it carries no reset.
  logic [XLEN-1:0] q_pc     [DEPTH];
  logic            q_taken  [DEPTH];
  logic [XLEN-1:0] q_target [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic            push, resolve, empty_resolve;
  logic            pc_mismatch, dir_miss, flush_now;
  logic [XLEN-1:0] head_pc, head_target, redirect;
  logic            head_taken;

  logic            resolved_p1, outcome_p1, flush_p1, order_error_p1;
  logic [XLEN-1:0] branch_pc_p1, redirect_pc_p1;

  assign pred_ready = (count < CW'(DEPTH));

  // Decode this cycle's push/resolve and the mispredict verdict against the head.
  always_comb begin
    push          = pred_valid & pred_ready;
    resolve       = ex_valid & (count != '0);
    empty_resolve = ex_valid & (count == '0);
    head_pc       = q_pc[rd_ptr];
    head_taken    = q_taken[rd_ptr];
    head_target   = q_target[rd_ptr];
    pc_mismatch   = resolve & (ex_pc != head_pc);
    dir_miss      = resolve & ((ex_taken != head_taken) |
                               (ex_taken & head_taken & (ex_target != head_target)));
    // A wrong-PC resolve means the queue is out of sync; recover as a mispredict.
    flush_now     = dir_miss | pc_mismatch;
    redirect      = ex_taken ? ex_target : (ex_pc + XLEN'(4));
  end

  // Queue pointers and occupancy; a mispredict drops every younger entry and any
  // push arriving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (resolve) rd_ptr <= rd_ptr + AW'(1);
      case ({push, resolve})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write the pushed prediction into the tail slot.
  always_ff @(posedge clk) begin
    if (push && !flush_now) begin
      q_pc[wr_ptr]     <= pred_pc;
      q_taken[wr_ptr]  <= pred_taken;
      q_target[wr_ptr] <= pred_target;
    end
  end

  // ---- stage p1: registered training / redirect outputs ----
  // Pulses are re-evaluated every cycle; PC fields hold until the next event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resolved_p1    <= 1'b0;
      outcome_p1     <= 1'b0;
      flush_p1       <= 1'b0;
      order_error_p1 <= 1'b0;
      branch_pc_p1   <= '0;
      redirect_pc_p1 <= '0;
    end else begin
      resolved_p1    <= resolve;
      flush_p1       <= flush_now;
      order_error_p1 <= pc_mismatch | empty_resolve;
      outcome_p1     <= resolve & ex_taken;
      if (resolve)   branch_pc_p1   <= ex_pc;
      if (flush_now) redirect_pc_p1 <= redirect;
    end
  end

  assign branch_resolved = resolved_p1;
  assign branch_outcome  = outcome_p1;
  assign flush           = flush_p1;
  assign order_error     = order_error_p1;
  assign branch_pc       = branch_pc_p1;
  assign redirect_pc     = redirect_pc_p1;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] resolved_cnt_p1, mispredict_cnt_p1;

  // Event counters advance together with the pulse they count and wrap freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resolved_cnt_p1   <= '0;
      mispredict_cnt_p1 <= '0;
    end else begin
      if (resolve)   resolved_cnt_p1   <= resolved_cnt_p1 + 32'd1;
      if (flush_now) mispredict_cnt_p1 <= mispredict_cnt_p1 + 32'd1;
    end
  end

  assign resolved_count   = resolved_cnt_p1;
  assign mispredict_count = mispredict_cnt_p1;
`endif

endmodule
